pll_phase_controller: RTL and testbench
=======================================

Name: pll_phase_controller

Overview:
Parametrised successor to the fixed-pattern PLL phase sweeper. It drives the Cyclone dynamic phase-shift interface (phasecounterselect, phaseupdown, phasestep, scanclk) from a command port, and supports absolute, relative, auto-sweep and PLL-reset operations. It tracks the current phase position with wrap-around, confirms every step against phase_done, and reports timeouts. It sits between the trigger board control logic and the PLL reconfiguration pins.

Parameters:
POS_MAX, 64, number of phase positions per full cycle (counter wraps modulo POS_MAX); POS_W = clog2(POS_MAX)
SCAN_DIV, 16, clk cycles per scanclk half-period (>=2)
HOLD_EDGES, 2, scanclk rising edges phasestep stays asserted
TIMEOUT_EDGES, 100, scanclk rising edges after deassert before giving up on phase_done
ARESET_CYC, 8, clk cycles areset is held high
LOCK_WAIT, 1024, clk cycles waited after areset release
DWELL_CYC, 5000000, clk cycles between auto-sweep steps (0.1 s at 50 MHz)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command strobe
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_mode  in  2  00 ABS, 01 REL, 10 SWEEP, 11 PLLRST
cmd_counter  in  3  phasecounterselect value for the command (000 all, 001 M, 010..110 C0..C4)
cmd_value  in  POS_W+1  ABS: target (unsigned, low POS_W bits); REL: signed step count; SWEEP: unsigned increment
phase_done  in  1  PLL phase-done (async, low while shifting)
areset  out  1  PLL async reset
phasecounterselect  out  3  registered counter select
phaseupdown  out  1  1 up, 0 down
phasestep  out  1  phase step request
scanclk  out  1  generated scan clock
cur_pos  out  POS_W  current tracked phase position
busy  out  1  high in any state other than IDLE and DWELL
sweep_active  out  1  auto-sweep running
timeout_err  out  1  sticky; cleared by the next accepted command
range_err  out  1  sticky; ABS target >= POS_MAX; cleared by the next accepted command

Behaviour:
- The following apply only when reset is high at a clk edge: all outputs 0 except phaseupdown=1 and cmd_ready=1; cur_pos=0; state IDLE. A reset mid-step aborts immediately, and there is no end-of-step handshake.
- phase_done passes through a 2-flop synchroniser, adding 2 clk of latency.
- States: IDLE, AR_HOLD, AR_WAIT, SETUP, STEP_ASSERT, STEP_WAIT, STEP_DONE, DWELL.
- cmd_ready=1 only in IDLE and DWELL. A command accepted in DWELL ends the sweep and is then executed.
- ABS: diff=(target-cur_pos) mod POS_MAX. If diff<=POS_MAX/2: up, diff steps; otherwise: down, POS_MAX-diff steps. If target>=POS_MAX: set range_err, no steps, return to IDLE.
- REL: sign selects direction (negative = down); magnitude is the step count. The magnitude is not reduced modulo POS_MAX.
- SWEEP: sweep_active=1, enter DWELL. After DWELL_CYC cycles, step up by the increment, then return to DWELL. Repeat forever. An increment of 0 dwells only.
- PLLRST: areset=1 for ARESET_CYC cycles (AR_HOLD), then 0 for LOCK_WAIT cycles (AR_WAIT). cur_pos=0, sweep stops, go to IDLE.
- A step count of 0 returns to IDLE one cycle after acceptance.
- SETUP (1 clk): latch phasecounterselect and phaseupdown, phasestep=1, scanclk=0, reset the divider.
- STEP_ASSERT: scanclk toggles every SCAN_DIV clk. After HOLD_EDGES scanclk rising edges, phasestep=0 and go to STEP_WAIT.
- STEP_WAIT: scanclk keeps toggling.
  - Completion: synced phase_done seen 0 at any point since SETUP, then seen 1.
  - On completion, go to STEP_DONE. cur_pos is updated ±1 modulo POS_MAX (63+1 -> 0, 0-1 -> 63) and scanclk is forced 0.
  - If TIMEOUT_EDGES rising edges pass without completion: set timeout_err, force scanclk=0, abandon the remaining steps, clear sweep_active, go to IDLE. cur_pos is not changed.
- STEP_DONE: if steps remain, go to SETUP; otherwise go to IDLE, or to DWELL if sweeping.
- phasecounterselect and phaseupdown are stable from SETUP until STEP_DONE. They only change when phasestep=0 and scanclk=0.

Test Plan:
- reset, then ABS target 5 (counter 000), PLL model pulses phase_done low per step -> exactly 5 phasestep pulses, phaseupdown=1, cur_pos=5, busy falls, cmd_ready returns 1.
- cur_pos=2, ABS 62 -> 4 down steps, cur_pos 2,1,0,63,62.
- cur_pos=0, REL -3 (cmd_value all-ones minus 2) -> phaseupdown=0, 3 steps, cur_pos=61. Then ABS 70 -> range_err=1, no phasestep.
- PLL model holds phase_done=1 forever, REL +2 -> one phasestep pulse, timeout_err=1 after 100 scanclk rising edges, cur_pos unchanged, state IDLE. The next command clears timeout_err.
- DWELL_CYC=100, SWEEP increment 3 -> one step group of 3 per 100-cycle dwell, cur_pos 3,6,...,63,2 (wrap). Then ABS 0 issued during DWELL -> sweep_active=0, cur_pos goes to 0.
- PLLRST -> areset high for exactly 8 clk, cmd_ready low for 8+1024 cycles, cur_pos=0. Assert reset during STEP_ASSERT -> the next cycle phasestep=0, scanclk=0, cur_pos=0, phaseupdown=1.

Source files
------------

// File: rtl/pll_phase_controller.sv
// Cyclone dynamic phase-shift controller: absolute, relative and auto-sweep moves plus PLL reset,
// with wrap-around position tracking and per-step phase_done confirmation.
module pll_phase_controller #(
    parameter int unsigned POS_MAX       = 64,
    parameter int unsigned SCAN_DIV      = 16,
    parameter int unsigned HOLD_EDGES    = 2,
    parameter int unsigned TIMEOUT_EDGES = 100,
    parameter int unsigned ARESET_CYC    = 8,
    parameter int unsigned LOCK_WAIT     = 1024,
    parameter int unsigned DWELL_CYC     = 5000000,
    localparam int unsigned POS_W        = $clog2(POS_MAX)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [2:0]       cmd_counter,
    input  logic [POS_W:0]   cmd_value,
    input  logic             phase_done,
    output logic             areset,
    output logic [2:0]       phasecounterselect,
    output logic             phaseupdown,
    output logic             phasestep,
    output logic             scanclk,
    output logic [POS_W-1:0] cur_pos,
    output logic             busy,
    output logic             sweep_active,
    output logic             timeout_err,
    output logic             range_err
);

    localparam int unsigned EDGE_W = $clog2(TIMEOUT_EDGES + HOLD_EDGES + 1);
    localparam int unsigned DIV_W  = $clog2(SCAN_DIV);

    localparam logic [POS_W:0]   PosMax    = (POS_W+1)'(POS_MAX);
    localparam logic [POS_W:0]   PosHalf   = (POS_W+1)'(POS_MAX / 2);
    localparam logic [POS_W-1:0] PosLast   = POS_W'(POS_MAX - 1);
    localparam logic [EDGE_W-1:0] HoldCnt  = EDGE_W'(HOLD_EDGES);
    localparam logic [EDGE_W-1:0] ToutCnt  = EDGE_W'(TIMEOUT_EDGES);
    localparam logic [DIV_W-1:0] DivLast   = DIV_W'(SCAN_DIV - 1);
    localparam logic [31:0]      ArLast    = 32'(ARESET_CYC - 1);
    localparam logic [31:0]      LockLast  = 32'(LOCK_WAIT - 1);
    localparam logic [31:0]      DwellLast = 32'(DWELL_CYC - 1);

    localparam logic [1:0] ModeAbs    = 2'b00;
    localparam logic [1:0] ModeRel    = 2'b01;
    localparam logic [1:0] ModeSweep  = 2'b10;
    localparam logic [1:0] ModePllRst = 2'b11;

    typedef enum logic [2:0] {
        StIdle, StArHold, StArWait, StSetup, StStepAssert, StStepWait, StStepDone, StDwell
    } state_e;

    state_e            state_q, state_d;
    logic              pd_meta_q, pd_sync_q, pd_low_q;
    logic [POS_W:0]    steps_q, inc_q;
    logic [31:0]       cyc_q;
    logic [DIV_W-1:0]  div_q;
    logic [EDGE_W-1:0] edge_q;
    logic              scanclk_q;
    logic [POS_W-1:0]  pos_q;
    logic [2:0]        sel_q, pend_sel_q;
    logic              dir_q, pend_dir_q;
    logic              sweep_q, tout_q, rng_q;

    logic              accept, tick, rise, step_ok, dwell_end, in_scan, stay_scan;
    logic [POS_W:0]    tgt, pos_ext, abs_diff, cmd_steps;
    logic              cmd_dir, cmd_range;

    assign accept    = cmd_valid && cmd_ready;
    assign in_scan   = state_q inside {StStepAssert, StStepWait};
    assign stay_scan = in_scan && (state_d inside {StStepAssert, StStepWait});
    assign tick      = in_scan && (div_q == DivLast);
    assign rise      = tick && !scanclk_q;
    assign step_ok   = pd_low_q && pd_sync_q;
    assign dwell_end = (state_q == StDwell) && (cyc_q == DwellLast);

    // Shortest-path direction for ABS; REL magnitude is taken as-is, not wrapped.
    always_comb begin
        tgt       = {1'b0, cmd_value[POS_W-1:0]};
        pos_ext   = {1'b0, pos_q};
        abs_diff  = (tgt >= pos_ext) ? tgt - pos_ext : tgt + PosMax - pos_ext;
        cmd_range = (cmd_mode == ModeAbs) && (cmd_value >= PosMax);
        cmd_dir   = 1'b1;
        cmd_steps = '0;
        if (cmd_mode == ModeAbs) begin
            if (!cmd_range) begin
                if (abs_diff <= PosHalf) begin
                    cmd_steps = abs_diff;
                end else begin
                    cmd_dir   = 1'b0;
                    cmd_steps = PosMax - abs_diff;
                end
            end
        end else if (cmd_mode == ModeRel) begin
            cmd_dir   = !cmd_value[POS_W];
            cmd_steps = cmd_value[POS_W] ? -cmd_value : cmd_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDwell: begin
                if (accept) begin
                    unique case (cmd_mode)
                        ModeSweep:  state_d = StDwell;
                        ModePllRst: state_d = StArHold;
                        default:    state_d = (cmd_steps != '0) ? StSetup : StStepDone;
                    endcase
                end else if (dwell_end) begin
                    state_d = (inc_q != '0) ? StSetup : StDwell;
                end
            end
            StArHold:     if (cyc_q == ArLast) state_d = StArWait;
            StArWait:     if (cyc_q == LockLast) state_d = StIdle;
            StSetup:      state_d = StStepAssert;
            StStepAssert: if (edge_q == HoldCnt) state_d = StStepWait;
            StStepWait: begin
                if (step_ok)                state_d = StStepDone;
                else if (edge_q == ToutCnt) state_d = StIdle;
            end
            StStepDone: begin
                if (steps_q != '0) state_d = StSetup;
                else               state_d = sweep_q ? StDwell : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready = state_q inside {StIdle, StDwell};
        busy      = !(state_q inside {StIdle, StDwell});
        areset    = (state_q == StArHold);
        phasestep = state_q inside {StSetup, StStepAssert};
    end

    assign scanclk            = scanclk_q;
    assign phasecounterselect = sel_q;
    assign phaseupdown        = dir_q;
    assign cur_pos            = pos_q;
    assign sweep_active       = sweep_q;
    assign timeout_err        = tout_q;
    assign range_err          = rng_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pd_meta_q  <= 1'b1;
            pd_sync_q  <= 1'b1;
            pd_low_q   <= 1'b0;
            steps_q    <= '0;
            inc_q      <= '0;
            cyc_q      <= '0;
            div_q      <= '0;
            edge_q     <= '0;
            scanclk_q  <= 1'b0;
            pos_q      <= '0;
            sel_q      <= '0;
            pend_sel_q <= '0;
            dir_q      <= 1'b1;
            pend_dir_q <= 1'b1;
            sweep_q    <= 1'b0;
            tout_q     <= 1'b0;
            rng_q      <= 1'b0;
        end else begin
            pd_meta_q <= phase_done;
            pd_sync_q <= pd_meta_q;

            if (state_d != state_q || dwell_end || accept) cyc_q <= '0;
            else                                           cyc_q <= cyc_q + 32'd1;

            div_q     <= (stay_scan && !tick) ? div_q + DIV_W'(1) : '0;
            scanclk_q <= stay_scan ? (scanclk_q ^ tick) : 1'b0;

            if (state_d != state_q) edge_q <= '0;
            else if (rise)          edge_q <= edge_q + EDGE_W'(1);

            if (state_d == StSetup) pd_low_q <= 1'b0;
            else if ((in_scan || state_q == StSetup) && !pd_sync_q) pd_low_q <= 1'b1;

            // Select/direction change only on entry to SETUP, while phasestep and scanclk are low.
            if (state_d == StSetup) begin
                sel_q <= accept ? cmd_counter : pend_sel_q;
                dir_q <= accept ? cmd_dir : pend_dir_q;
            end

            if (accept) begin
                tout_q <= 1'b0;
                rng_q  <= cmd_range;
                unique case (cmd_mode)
                    ModeSweep: begin
                        sweep_q    <= 1'b1;
                        inc_q      <= cmd_value;
                        pend_sel_q <= cmd_counter;
                        pend_dir_q <= 1'b1;
                    end
                    ModePllRst: begin
                        sweep_q <= 1'b0;
                        pos_q   <= '0;
                    end
                    default: begin
                        sweep_q    <= 1'b0;
                        steps_q    <= cmd_steps;
                        pend_sel_q <= cmd_counter;
                        pend_dir_q <= cmd_dir;
                    end
                endcase
            end else if (dwell_end) begin
                steps_q <= inc_q;
            end else if (state_q == StStepWait && state_d == StStepDone) begin
                steps_q <= steps_q - (POS_W+1)'(1);
                if (dir_q) pos_q <= (pos_q == PosLast) ? '0 : pos_q + POS_W'(1);
                else       pos_q <= (pos_q == '0) ? PosLast : pos_q - POS_W'(1);
            end else if (state_q == StStepWait && state_d == StIdle) begin
                tout_q  <= 1'b1;
                sweep_q <= 1'b0;
                steps_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pll_phase_controller.sv
// Directed bench for pll_phase_controller with a simple PLL phase_done model.
module tb_pll_phase_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_mode = 2'b00;
    logic [2:0] cmd_counter = 3'b000;
    logic [6:0] cmd_value = 7'd0;
    logic       phase_done = 1'b1;
    logic       areset;
    logic [2:0] phasecounterselect;
    logic       phaseupdown, phasestep, scanclk;
    logic [5:0] cur_pos;
    logic       busy, sweep_active, timeout_err, range_err;

    int n_cmp = 0;
    int n_err = 0;
    int pulse_total = 0;
    int rise_total = 0;
    bit pll_stuck = 1'b0;
    bit rec_en = 1'b0;
    int sweep_log[$];
    int last_dwell = 0;

    pll_phase_controller #(
        .POS_MAX      (64),
        .SCAN_DIV     (4),
        .HOLD_EDGES   (2),
        .TIMEOUT_EDGES(100),
        .ARESET_CYC   (8),
        .LOCK_WAIT    (1024),
        .DWELL_CYC    (100)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_mode          (cmd_mode),
        .cmd_counter       (cmd_counter),
        .cmd_value         (cmd_value),
        .phase_done        (phase_done),
        .areset            (areset),
        .phasecounterselect(phasecounterselect),
        .phaseupdown       (phaseupdown),
        .phasestep         (phasestep),
        .scanclk           (scanclk),
        .cur_pos           (cur_pos),
        .busy              (busy),
        .sweep_active      (sweep_active),
        .timeout_err       (timeout_err),
        .range_err         (range_err)
    );

    initial forever #5 clk = ~clk;

    // PLL model: phase_done dips low for a few clocks after each phasestep request.
    initial forever begin
        @(posedge phasestep);
        pulse_total++;
        if (!pll_stuck) begin
            repeat (3) @(posedge clk);
            #1 phase_done = 1'b0;
            repeat (6) @(posedge clk);
            #1 phase_done = 1'b1;
        end
    end

    initial forever begin
        @(posedge scanclk);
        if (!phasestep) rise_total++;
    end

    initial begin
        bit prev_ready;
        int run;
        prev_ready = 1'b1;
        run = 0;
        forever begin
            @(negedge clk);
            if (rec_en && sweep_active && cmd_ready && !prev_ready)
                sweep_log.push_back(int'(cur_pos));
            if (sweep_active && cmd_ready) begin
                run++;
            end else begin
                if (run > 0) last_dwell = run;
                run = 0;
            end
            prev_ready = cmd_ready;
        end
    end

    task automatic send_cmd(input logic [1:0] m, input logic [2:0] c, input logic [6:0] v);
        int n;
        @(negedge clk);
        cmd_mode = m;
        cmd_counter = c;
        cmd_value = v;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            n_cmp++; n_err++;
            $display("FAIL cmd_accept: cmd_ready stayed %0b, want 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, want 0", busy, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0b want 1", cmd_ready); end
        n_cmp++; if (phaseupdown !== 1'b1) begin n_err++; $display("FAIL rst_updown: got %0b want 1", phaseupdown); end
        n_cmp++; if ({areset, phasestep, scanclk, busy, sweep_active, timeout_err, range_err} !== 7'd0) begin
            n_err++; $display("FAIL rst_flags: got %b want 0000000",
                {areset, phasestep, scanclk, busy, sweep_active, timeout_err, range_err}); end
        n_cmp++; if ({phasecounterselect, cur_pos} !== 9'd0) begin
            n_err++; $display("FAIL rst_sel_pos: got sel %0d pos %0d want 0 0", phasecounterselect, cur_pos); end
        reset = 1'b0;
    endtask

    task automatic test_abs_up();
        int p0;
        p0 = pulse_total;
        send_cmd(2'b00, 3'b000, 7'd5);
        wait_idle(2000);
        n_cmp++; if (pulse_total - p0 !== 5) begin n_err++; $display("FAIL abs5_pulses: got %0d want 5", pulse_total - p0); end
        n_cmp++; if (phaseupdown !== 1'b1) begin n_err++; $display("FAIL abs5_updown: got %0b want 1", phaseupdown); end
        n_cmp++; if (cur_pos !== 6'd5) begin n_err++; $display("FAIL abs5_pos: got %0d want 5", cur_pos); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL abs5_ready: got %0b want 1", cmd_ready); end
    endtask

    task automatic test_abs_down_wrap();
        int p0, n;
        int seq[$];
        logic [5:0] prev;
        int exp_seq[4];
        exp_seq = '{1, 0, 63, 62};
        send_cmd(2'b00, 3'b000, 7'd2);
        wait_idle(2000);
        n_cmp++; if (cur_pos !== 6'd2) begin n_err++; $display("FAIL abs2_pos: got %0d want 2", cur_pos); end
        p0 = pulse_total;
        send_cmd(2'b00, 3'b001, 7'd62);
        prev = 6'd2;
        n = 0;
        while (busy && n < 2000) begin
            if (cur_pos !== prev) begin seq.push_back(int'(cur_pos)); prev = cur_pos; end
            @(negedge clk);
            n++;
        end
        if (cur_pos !== prev) seq.push_back(int'(cur_pos));
        n_cmp++; if (pulse_total - p0 !== 4) begin n_err++; $display("FAIL abs62_pulses: got %0d want 4", pulse_total - p0); end
        n_cmp++; if (seq.size() !== 4) begin n_err++; $display("FAIL abs62_len: got %0d want 4", seq.size()); end
        for (int i = 0; i < 4 && i < seq.size(); i++) begin
            n_cmp++;
            if (seq[i] !== exp_seq[i]) begin n_err++; $display("FAIL abs62_seq[%0d]: got %0d want %0d", i, seq[i], exp_seq[i]); end
        end
        n_cmp++; if (phaseupdown !== 1'b0) begin n_err++; $display("FAIL abs62_updown: got %0b want 0", phaseupdown); end
        n_cmp++; if (phasecounterselect !== 3'b001) begin n_err++; $display("FAIL abs62_sel: got %0d want 1", phasecounterselect); end
    endtask

    task automatic test_rel_and_range();
        int p0;
        send_cmd(2'b00, 3'b000, 7'd0);
        wait_idle(2000);
        n_cmp++; if (cur_pos !== 6'd0) begin n_err++; $display("FAIL abs0_pos: got %0d want 0", cur_pos); end
        p0 = pulse_total;
        send_cmd(2'b01, 3'b010, 7'b1111101);
        wait_idle(2000);
        n_cmp++; if (pulse_total - p0 !== 3) begin n_err++; $display("FAIL relm3_pulses: got %0d want 3", pulse_total - p0); end
        n_cmp++; if (phaseupdown !== 1'b0) begin n_err++; $display("FAIL relm3_updown: got %0b want 0", phaseupdown); end
        n_cmp++; if (cur_pos !== 6'd61) begin n_err++; $display("FAIL relm3_pos: got %0d want 61", cur_pos); end
        p0 = pulse_total;
        send_cmd(2'b00, 3'b000, 7'd70);
        wait_idle(20);
        n_cmp++; if (range_err !== 1'b1) begin n_err++; $display("FAIL abs70_range: got %0b want 1", range_err); end
        n_cmp++; if (pulse_total - p0 !== 0) begin n_err++; $display("FAIL abs70_pulses: got %0d want 0", pulse_total - p0); end
        n_cmp++; if (cur_pos !== 6'd61) begin n_err++; $display("FAIL abs70_pos: got %0d want 61", cur_pos); end
    endtask

    task automatic test_timeout();
        int p0, r0;
        pll_stuck = 1'b1;
        p0 = pulse_total;
        send_cmd(2'b01, 3'b000, 7'd2);
        r0 = rise_total;
        n_cmp++; if (range_err !== 1'b0) begin n_err++; $display("FAIL tout_range_clr: got %0b want 0", range_err); end
        wait_idle(3000);
        n_cmp++; if (pulse_total - p0 !== 1) begin n_err++; $display("FAIL tout_pulses: got %0d want 1", pulse_total - p0); end
        n_cmp++; if (rise_total - r0 !== 100) begin n_err++; $display("FAIL tout_edges: got %0d want 100", rise_total - r0); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tout_flag: got %0b want 1", timeout_err); end
        n_cmp++; if (cur_pos !== 6'd61) begin n_err++; $display("FAIL tout_pos: got %0d want 61", cur_pos); end
        n_cmp++; if ({scanclk, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL tout_idle: got scanclk/ready %b want 01", {scanclk, cmd_ready}); end
        pll_stuck = 1'b0;
        send_cmd(2'b01, 3'b000, 7'd0);
        wait_idle(20);
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tout_clear: got %0b want 0", timeout_err); end
    endtask

    task automatic test_sweep();
        int n;
        send_cmd(2'b00, 3'b000, 7'd0);
        wait_idle(2000);
        n_cmp++; if (cur_pos !== 6'd0) begin n_err++; $display("FAIL sw_start_pos: got %0d want 0", cur_pos); end
        sweep_log.delete();
        rec_en = 1'b1;
        send_cmd(2'b10, 3'b011, 7'd3);
        n_cmp++; if ({sweep_active, busy} !== 2'b10) begin n_err++; $display("FAIL sw_active: got active/busy %b want 10", {sweep_active, busy}); end
        n = 0;
        while (sweep_log.size() < 22 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        rec_en = 1'b0;
        n_cmp++; if (sweep_log.size() < 22) begin n_err++; $display("FAIL sw_groups: got %0d want 22", sweep_log.size()); end
        for (int k = 0; k < 22 && k < sweep_log.size(); k++) begin
            n_cmp++;
            if (sweep_log[k] !== (3 * (k + 1)) % 64) begin
                n_err++; $display("FAIL sw_pos[%0d]: got %0d want %0d", k, sweep_log[k], (3 * (k + 1)) % 64);
            end
        end
        n_cmp++; if (last_dwell !== 100) begin n_err++; $display("FAIL sw_dwell: got %0d want 100", last_dwell); end
        send_cmd(2'b00, 3'b000, 7'd0);
        n_cmp++; if (sweep_active !== 1'b0) begin n_err++; $display("FAIL sw_stop: got %0b want 0", sweep_active); end
        wait_idle(2000);
        n_cmp++; if (cur_pos !== 6'd0) begin n_err++; $display("FAIL sw_abs0_pos: got %0d want 0", cur_pos); end
        n_cmp++; if ({sweep_active, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL sw_abs0_idle: got %b want 01", {sweep_active, cmd_ready}); end
    endtask

    task automatic test_pllrst();
        int n, ar;
        send_cmd(2'b00, 3'b000, 7'd5);
        wait_idle(2000);
        send_cmd(2'b11, 3'b000, 7'd0);
        n = 0;
        ar = 0;
        while (!cmd_ready && n < 3000) begin
            if (areset) ar++;
            @(negedge clk);
            n++;
        end
        n_cmp++; if (ar !== 8) begin n_err++; $display("FAIL rst_areset_len: got %0d want 8", ar); end
        n_cmp++; if (n !== 1032) begin n_err++; $display("FAIL rst_notready_len: got %0d want 1032", n); end
        n_cmp++; if (cur_pos !== 6'd0) begin n_err++; $display("FAIL pllrst_pos: got %0d want 0", cur_pos); end
        n_cmp++; if (areset !== 1'b0) begin n_err++; $display("FAIL pllrst_areset_end: got %0b want 0", areset); end
    endtask

    task automatic test_reset_mid_step();
        int n;
        send_cmd(2'b00, 3'b010, 7'd60);
        n = 0;
        while (cur_pos !== 6'd62 && n < 2000) begin @(negedge clk); n++; end
        while (!phasestep && n < 2000) begin @(negedge clk); n++; end
        repeat (6) @(negedge clk);
        n_cmp++; if ({phasestep, phaseupdown} !== 2'b10) begin
            n_err++; $display("FAIL mid_pre: got step/updown %b want 10", {phasestep, phaseupdown}); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if ({phasestep, scanclk} !== 2'b00) begin n_err++; $display("FAIL mid_step_scan: got %b want 00", {phasestep, scanclk}); end
        n_cmp++; if (cur_pos !== 6'd0) begin n_err++; $display("FAIL mid_pos: got %0d want 0", cur_pos); end
        n_cmp++; if (phaseupdown !== 1'b1) begin n_err++; $display("FAIL mid_updown: got %0b want 1", phaseupdown); end
        n_cmp++; if ({busy, cmd_ready} !== 2'b01) begin n_err++; $display("FAIL mid_idle: got busy/ready %b want 01", {busy, cmd_ready}); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_abs_up();
        test_abs_down_wrap();
        test_rel_and_range();
        test_timeout();
        test_sweep();
        test_pllrst();
        test_reset_mid_step();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
